// File: rtl/sram_ctrl_pkg.sv
// Shared constants and request type for the 512x64 single-port SRAM macro interface.
package sram_ctrl_pkg;

    localparam int SRAM_WIDTH      = 64;
    localparam int SRAM_ADDR_WIDTH = 9;
    localparam int SRAM_DEPTH      = 512;

    localparam logic [1:0] SRAM_RTSEL_DEF = 2'b00;
    localparam logic [1:0] SRAM_WTSEL_DEF = 2'b00;

    typedef struct packed {
        logic                       write;
        logic [SRAM_ADDR_WIDTH-1:0] addr;
        logic [SRAM_WIDTH-1:0]      data;
        logic [SRAM_WIDTH-1:0]      bmask;
    } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding read responses the consumer has not yet taken.
// Storage is deliberately left unreset; only pointers and occupancy are cleared.
module sram_rsp_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sram_req_ctrl.sv
// Request-side controller for the single-port SRAM macro with credit-gated read responses.
// Optional performance counters are enabled by defining SRAM_REQ_CTRL_PERF_EN.
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int         WIDTH      = SRAM_WIDTH,
    parameter int         ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int         RSP_DEPTH  = 2,
    parameter logic [1:0] RTSEL_VAL  = SRAM_RTSEL_DEF,
    parameter logic [1:0] WTSEL_VAL  = SRAM_WTSEL_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_data,
    input  logic [WIDTH-1:0]      req_bmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  sram_ceb,
    output logic                  sram_web,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [WIDTH-1:0]      sram_d,
    output logic [WIDTH-1:0]      sram_bweb,
    output logic [1:0]            sram_rtsel,
    output logic [1:0]            sram_wtsel,
    input  logic [WIDTH-1:0]      sram_q
`ifdef SRAM_REQ_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_rd_cnt,
    output logic [31:0]           perf_wr_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(RSP_DEPTH);

    logic          fire;
    logic          rd_fire;
    logic          inflight_p1;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [WIDTH-1:0] fifo_head;
    logic [CW:0]   used;

    // Every accepted read owns a slot until its data is handed to the consumer.
    assign used      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_p1};
    assign req_ready = !reset && !fifo_full && (used < CREDITS);
    assign fire      = req_valid && req_ready;
    assign rd_fire   = fire && !req_write;

    assign sram_ceb   = ~fire;
    assign sram_web   = ~req_write;
    assign sram_a     = req_addr;
    assign sram_d     = req_data;
    assign sram_bweb  = ~req_bmask;
    assign sram_rtsel = RTSEL_VAL;
    assign sram_wtsel = WTSEL_VAL;

    // Stage p1: macro output is valid one cycle after a read fire.
    always_ff @(posedge clk) begin
        if (reset) inflight_p1 <= 1'b0;
        else       inflight_p1 <= rd_fire;
    end

    // Empty FIFO lets sram_q bypass straight out; otherwise it queues behind the head.
    assign rsp_valid = !reset && (inflight_p1 || !fifo_empty);
    assign rsp_data  = fifo_empty ? sram_q : fifo_head;
    assign fifo_push = !reset && inflight_p1 && !(fifo_empty && rsp_ready);
    assign fifo_pop  = !reset && !fifo_empty && rsp_ready;

    sram_rsp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (sram_q),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef SRAM_REQ_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_rd_cnt    <= '0;
            perf_wr_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (rd_fire)                perf_rd_cnt    <= perf_rd_cnt + 32'd1;
            if (fire && req_write)      perf_wr_cnt    <= perf_wr_cnt + 32'd1;
            if (req_valid && !req_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural SRAM macro and a transaction-level reference.
module tb_sram_req_ctrl;

    localparam int AW    = 9;
    localparam int W     = 64;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [W-1:0]  req_data = '0;
    logic [W-1:0]  req_bmask = '0;
    logic          rsp_ready = 1'b1;
    logic          req_ready;
    logic          rsp_valid;
    logic [W-1:0]  rsp_data;
    logic          sram_ceb;
    logic          sram_web;
    logic [AW-1:0] sram_a;
    logic [W-1:0]  sram_d;
    logic [W-1:0]  sram_bweb;
    logic [1:0]    sram_rtsel;
    logic [1:0]    sram_wtsel;
    logic [W-1:0]  sram_q = '0;
`ifdef SRAM_REQ_CTRL_PERF_EN
    logic [31:0]   perf_rd_cnt;
    logic [31:0]   perf_wr_cnt;
    logic [31:0]   perf_stall_cnt;
    int            m_rd = 0, m_wr = 0, m_stall = 0;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] mem  [512];
    logic [W-1:0] gmem [512];
    logic [W-1:0] expq [$];

    always #5 clk = ~clk;

    sram_req_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_bmask  (req_bmask),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .sram_ceb   (sram_ceb),
        .sram_web   (sram_web),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_bweb  (sram_bweb),
        .sram_rtsel (sram_rtsel),
        .sram_wtsel (sram_wtsel),
        .sram_q     (sram_q)
`ifdef SRAM_REQ_CTRL_PERF_EN
        ,
        .perf_rd_cnt    (perf_rd_cnt),
        .perf_wr_cnt    (perf_wr_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]  = 64'(i) * 64'h9E37_79B9_7F4A_7C15;
            gmem[i] = 64'(i) * 64'h9E37_79B9_7F4A_7C15;
        end
    end

    // Behavioural macro: masked write, registered read.
    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web) mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_d & ~sram_bweb);
            else           sram_q <= mem[sram_a];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every accepted read is owed one response, in order, available the cycle after acceptance.
    always @(negedge clk) begin : cmp
        logic e_ready, e_valid, e_fire;
        if (reset) begin
            expq.delete();
`ifdef SRAM_REQ_CTRL_PERF_EN
            m_rd = 0; m_wr = 0; m_stall = 0;
`endif
            chk("req_ready_in_reset", 64'(req_ready), 64'd0);
            chk("rsp_valid_in_reset", 64'(rsp_valid), 64'd0);
            chk("sram_ceb_in_reset", 64'(sram_ceb), 64'd1);
        end else begin
            e_ready = expq.size() < DEPTH;
            e_valid = expq.size() > 0;
            e_fire  = req_valid && e_ready;
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
            chk("sram_ceb", 64'(sram_ceb), 64'(!e_fire));
            chk("sram_rtsel", 64'(sram_rtsel), 64'd0);
            chk("sram_wtsel", 64'(sram_wtsel), 64'd0);
            if (e_fire) begin
                chk("sram_web", 64'(sram_web), 64'(!req_write));
                chk("sram_a", 64'(sram_a), 64'(req_addr));
                chk("sram_d", sram_d, req_data);
                chk("sram_bweb", sram_bweb, ~req_bmask);
            end
            if (e_valid) chk("rsp_data", rsp_data, expq[0]);
`ifdef SRAM_REQ_CTRL_PERF_EN
            chk("perf_rd_cnt", 64'(perf_rd_cnt), 64'(m_rd));
            chk("perf_wr_cnt", 64'(perf_wr_cnt), 64'(m_wr));
            chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall));
            if (e_fire && !req_write) m_rd++;
            if (e_fire && req_write)  m_wr++;
            if (req_valid && !e_ready) m_stall++;
`endif
            if (e_valid && rsp_ready) void'(expq.pop_front());
            if (e_fire && !req_write) expq.push_back(gmem[req_addr]);
            if (e_fire && req_write)
                gmem[req_addr] = (gmem[req_addr] & ~req_bmask) | (req_data & req_bmask);
        end
    end

    task automatic step(input logic rs, input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input logic [W-1:0] m, input logic r);
        @(posedge clk);
        #1;
        reset = rs; req_valid = v; req_write = w; req_addr = a;
        req_data = d; req_bmask = m; rsp_ready = r;
        @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
        step(1'b0, 1'b1, 1'b1, a, d, m, 1'b1);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic r);
        step(1'b0, 1'b1, 1'b0, a, '0, '0, r);
    endtask

    task automatic idle(input logic r);
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, r);
    endtask

    initial begin : stim
        int n;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 9'h003, '0, '0, 1'b1);
            chk("lit_rst_ready", 64'(req_ready), 64'd0);
            chk("lit_rst_ceb", 64'(sram_ceb), 64'd1);
        end
        idle(1'b1);
        chk("lit_post_rst_ready", 64'(req_ready), 64'd1);

        // Write then bypassed read.
        wr(9'h005, 64'hDEAD_BEEF_0123_4567, '1);
        chk("lit_wr_ceb", 64'(sram_ceb), 64'd0);
        rd(9'h005, 1'b1);
        chk("lit_rd_web", 64'(sram_web), 64'd1);
        idle(1'b1);
        chk("lit_bypass_valid", 64'(rsp_valid), 64'd1);
        chk("lit_bypass_data", rsp_data, 64'hDEAD_BEEF_0123_4567);

        // Partial mask, then an all-zero mask write that must change nothing.
        wr(9'h010, 64'h0, '1);
        wr(9'h010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000);
        chk("lit_bweb", sram_bweb, 64'hFFFF_FFFF_0000_FFFF);
        rd(9'h010, 1'b1);
        idle(1'b1);
        chk("lit_masked_data", rsp_data, 64'h0000_0000_FFFF_0000);
        wr(9'h010, 64'h1234_5678_9ABC_DEF0, '0);
        chk("lit_zero_mask_ceb", 64'(sram_ceb), 64'd0);
        rd(9'h010, 1'b1);
        idle(1'b1);
        chk("lit_zero_mask_data", rsp_data, 64'h0000_0000_FFFF_0000);

        // Backpressure: only two reads accepted while the consumer stalls.
        wr(9'h001, 64'h1111_1111_1111_1111, '1);
        wr(9'h002, 64'h2222_2222_2222_2222, '1);
        wr(9'h003, 64'h3333_3333_3333_3333, '1);
        wr(9'h004, 64'h4444_4444_4444_4444, '1);
        rd(9'h001, 1'b0);
        chk("lit_bp_ready1", 64'(req_ready), 64'd1);
        rd(9'h002, 1'b0);
        chk("lit_bp_ready2", 64'(req_ready), 64'd1);
        rd(9'h003, 1'b0);
        chk("lit_bp_ready3", 64'(req_ready), 64'd0);
        rd(9'h003, 1'b0);
        chk("lit_bp_ready4", 64'(req_ready), 64'd0);
        chk("lit_bp_head", rsp_data, 64'h1111_1111_1111_1111);
        rd(9'h003, 1'b1);
        chk("lit_bp_full_pop_ready", 64'(req_ready), 64'd0);
        chk("lit_bp_rsp1", rsp_data, 64'h1111_1111_1111_1111);
        rd(9'h003, 1'b1);
        chk("lit_bp_resume", 64'(req_ready), 64'd1);
        chk("lit_bp_rsp2", rsp_data, 64'h2222_2222_2222_2222);
        rd(9'h004, 1'b1);
        chk("lit_bp_rsp3", rsp_data, 64'h3333_3333_3333_3333);
        idle(1'b1);
        chk("lit_bp_rsp4", rsp_data, 64'h4444_4444_4444_4444);
        idle(1'b1);
        chk("lit_bp_drained", 64'(rsp_valid), 64'd0);

        // Back-to-back reads at full throughput.
        n = 0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) begin
                rd(AW'(i), 1'b1);
                chk("lit_b2b_ready", 64'(req_ready), 64'd1);
            end else begin
                idle(1'b1);
            end
            if (rsp_valid) n++;
        end
        chk("lit_b2b_rsp_count", 64'(n), 64'd16);

        // Reset while a read is in flight: its data must never appear.
        rd(9'h007, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        chk("lit_rst_inflight_valid", 64'(rsp_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk("lit_after_rst_valid", 64'(rsp_valid), 64'd0);
            chk("lit_after_rst_ceb", 64'(sram_ceb), 64'd1);
            chk("lit_after_rst_ready", 64'(req_ready), 64'd1);
        end

`ifdef SRAM_REQ_CTRL_PERF_EN
        chk("lit_perf_zero", 64'(perf_rd_cnt + perf_wr_cnt + perf_stall_cnt), 64'd0);
        wr(9'h014, 64'hA, '1);
        wr(9'h015, 64'hB, '1);
        wr(9'h016, 64'hC, '1);
        rd(9'h014, 1'b0);
        rd(9'h015, 1'b0);
        rd(9'h016, 1'b0);
        rd(9'h016, 1'b1);
        rd(9'h016, 1'b1);
        rd(9'h017, 1'b1);
        rd(9'h018, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("lit_perf_wr", 64'(perf_wr_cnt), 64'd3);
        chk("lit_perf_rd", 64'(perf_rd_cnt), 64'd5);
        chk("lit_perf_stall", 64'(perf_stall_cnt), 64'd2);
`endif

        idle(1'b1);
        idle(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Initiator side of the 512x64 single-port SRAM macro interface. Accepts valid/ready read/write requests and drives the macro's active-low CEB/WEB/BWEB pins.
- Tracks the macro's 1-cycle read latency. Returns read data on a valid/ready response channel with credit-based backpressure.
- Sits between memory_core address generators and the SRAM macro instance.

Parameters:
- WIDTH, 64, data and bit-mask width
- ADDR_WIDTH, 9, word address width (2**ADDR_WIDTH words)
- RSP_DEPTH, 2, response FIFO entries; also the max reads in flight plus buffered
- RTSEL_VAL, 2'b00, constant driven on sram_rtsel
- WTSEL_VAL, 2'b00, constant driven on sram_wtsel

Ports:
- clk  input  1  clock; also clocks the SRAM macro
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when req_valid && req_ready (fire)
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  word address
- req_data  input  WIDTH  write data
- req_bmask  input  WIDTH  active-high bit write enable
- rsp_valid  output  1  read data valid
- rsp_ready  input  1  consumer ready
- rsp_data  output  WIDTH  read data
- sram_ceb  output  1  chip enable, active-low
- sram_web  output  1  write enable, active-low
- sram_a  output  ADDR_WIDTH  address
- sram_d  output  WIDTH  write data
- sram_bweb  output  WIDTH  bit write enable, active-low
- sram_rtsel  output  2  tie-off (RTSEL_VAL)
- sram_wtsel  output  2  tie-off (WTSEL_VAL)
- sram_q  input  WIDTH  macro read data

Behaviour:
- Macro pins are combinational from the current request:
  - sram_ceb = ~fire
  - sram_web = ~req_write
  - sram_a = req_addr
  - sram_d = req_data
  - sram_bweb = ~req_bmask
- A write with an all-zero mask still pulses CEB and updates nothing.
- req_ready = !reset && (inflight + fifo_count < RSP_DEPTH). Ready does not depend on req_write or req_valid. Writes consume no credit but are gated by the same ready.
- inflight: 1-bit register, set in the cycle after a read fire, else cleared.
- Read latency: sram_q is valid in the cycle after a read fire (cycle N+1).
  - FIFO empty in N+1: bypass, rsp_valid=1 and rsp_data=sram_q in N+1.
  - Bypass data not taken (rsp_ready=0): sram_q is pushed into the FIFO.
  - FIFO non-empty: sram_q is pushed; rsp drives the FIFO head.
- Strict in-order responses; one response per read.
- Write-then-read to the same address in consecutive cycles returns the new data. Writes produce no response. sram_q following a write cycle is ignored.
- Full throughput: back-to-back reads with rsp_ready=1 give one response per cycle. With rsp_ready=0, at most RSP_DEPTH reads are accepted, then req_ready=0.
- Simultaneous push and pop on a full FIFO is legal and occupancy is unchanged. Pop on empty is impossible (rsp_valid=0).
- Reset (any cycle, including mid-read):
  - FIFO emptied, inflight=0, rsp_valid=0, req_ready=0, sram_ceb=1.
  - An in-flight read's data is discarded.
  - FIFO data contents are not reset.

Optional Feature:
- Macro SRAM_REQ_CTRL_PERF_EN.
- Defined: adds outputs perf_rd_cnt[31:0], perf_wr_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_rd_cnt and perf_wr_cnt increment on read/write fire.
  - perf_stall_cnt increments each cycle with req_valid && !req_ready.
  - All three wrap at 2**32 and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package sram_ctrl_pkg holds:
  - SRAM_WIDTH=64, SRAM_ADDR_WIDTH=9, SRAM_DEPTH=512
  - default RTSEL/WTSEL constants
  - typedef sram_req_t {write, addr, data, bmask}
- Sub-module sram_rsp_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count.

Test Plan:
- Write addr 9'h005 data 64'hDEAD_BEEF_0123_4567, mask all-ones; read 9'h005 -> rsp_data 64'hDEAD_BEEF_0123_4567 exactly 1 cycle after read fire (bypass).
- Preload 64'h0; write 64'hFFFF_FFFF_FFFF_FFFF with mask 64'h0000_0000_FFFF_0000; read -> 64'h0000_0000_FFFF_0000; check sram_bweb = 64'hFFFF_FFFF_0000_FFFF on the write cycle.
- rsp_ready=0, issue 4 reads (addr 1..4) -> only 2 accepted, req_ready low from the 3rd cycle; release rsp_ready -> data for addr 1, 2 in order, then remaining reads accepted.
- Back-to-back reads addr 0..15 with rsp_ready=1 -> 16 responses on 16 consecutive cycles, in order, req_ready held high.
- Assert reset the cycle after a read fire -> no rsp_valid ever for that read; after reset release rsp_valid=0, sram_ceb=1, req_ready=1.
- With SRAM_REQ_CTRL_PERF_EN: 3 writes, 5 reads, 2 stall cycles -> perf_wr_cnt=3, perf_rd_cnt=5, perf_stall_cnt=2.
